dna_max_tracker: RTL
====================

# dna_max_tracker

Result collector at the output end of the Smith-Waterman PE array. Consumes the cell-score stream from the last PE (`score_o` with its enable) in row-major order, tracks the maximum local-alignment score and its (row, col) coordinate, and presents the final result to the host through a valid/ready handshake. It sits between the systolic array and the register/readout logic.

## Interface
- `SCORE_W`, 32: score width; matches PE `score_o`.
- `ROW_W`, 8: row index width; maximum rows 2^ROW_W − 1.
- `COL_W`, 8: column index width; maximum columns 2^COL_W − 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle pulse; begins a new alignment and latches the dimensions.
- `num_rows_i`  in  ROW_W  rows in the matrix (read length); sampled on `start_i`.
- `num_cols_i`  in  COL_W  columns in the matrix (reference length); sampled on `start_i`.
- `en_i`  in  1  cell-score valid from the PE array.
- `score_i`  in  SCORE_W  cell score, unsigned; SW scores are clamped at 0.
- `res_ready_i`  in  1  host accepts the result.
- `busy_o`  out  1  high in RUN.
- `res_valid_o`  out  1  result valid; high in DONE.
- `max_score_o`  out  SCORE_W  running/final maximum score.
- `max_row_o`  out  ROW_W  row of the maximum.
- `max_col_o`  out  COL_W  column of the maximum.
- `drop_o`  out  1  sticky: `en_i` seen outside RUN; cleared on `start_i`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start_i` → latch dimensions; clear max/row/col, the internal counters `row_cnt`/`col_cnt`, and `drop_o`; go to RUN. If either dimension is 0, go straight to DONE with max 0 and coordinates 0.
- RUN, per cycle with `en_i`=1:
  - If `score_i` > `max_score_o` (strictly greater), load score, `row_cnt`, and `col_cnt`. Ties keep the earliest cell.
  - If `col_cnt` == cols−1, set `col_cnt`=0 and increment `row_cnt`. Otherwise increment `col_cnt`.
  - On the last cell (`row_cnt`==rows−1, `col_cnt`==cols−1), go to DONE. The compare for this last cell is included.
- RUN with `en_i`=0: hold everything.
- RUN with `start_i`: abort and restart exactly as from IDLE. `start_i` takes priority over a same-cycle `en_i`, and that beat is discarded.
- DONE: `res_valid_o`=1. Outputs are frozen until `res_ready_i`=1, then go to IDLE. The outputs keep their values in IDLE until the next start.
- DONE: `start_i` is ignored unless `res_ready_i` is also high that cycle. In that case the result is consumed and the FSM goes directly to RUN with the new dimensions.
- `en_i` in IDLE or DONE: the beat is ignored and `drop_o` is set.
- All arithmetic is unsigned. Counters never exceed the latched dimensions, so no wrap beyond them.

## Timing
- Reset values: `busy_o`=0, `res_valid_o`=0, `max_score_o`=0, `max_row_o`=0, `max_col_o`=0, `drop_o`=0, state IDLE.
- `busy_o` rises the cycle after `start_i`. The first accepted `en_i` beat is the cycle after `start_i`.
- Max registers update on the same edge that accepts the beat, so latency is 1 cycle.
- `res_valid_o` rises on the edge that accepts the final cell. It is visible in the cycle after that beat, and `busy_o` falls on the same edge.
- Zero-dimension start: `res_valid_o` is high 1 cycle after `start_i`.
- Handshake: the result transfers on the edge where `res_valid_o` and `res_ready_i` are both 1. `res_valid_o` deasserts after that edge. No combinational path from `res_ready_i` to any output.
- Asserting `rst` mid-RUN or in DONE returns to reset values immediately, regardless of clock.

## Test plan
- 2×2 matrix, scores 3, 7, 7, 2, `res_ready_i`=1: `res_valid_o` for 1 cycle with max=7, row=0, col=1 (tie keeps the first).
- 3×4 matrix with `en_i` gaps, peak 9 at cell index 6: max=9, row=1, col=2; `busy_o` stays high through the gaps.
- Hold `res_ready_i`=0 for 5 cycles in DONE with `en_i` pulsing: outputs stay frozen and `drop_o`=1. Then `start_i` clears `drop_o`.
- `start_i` after 3 beats of a 2×4 run, then a new 1×1 run with score 4: result is max=4, row 0, col 0; the aborted data is not reflected.
- `num_rows_i`=0: `res_valid_o`=1 one cycle after `start_i`, max 0.
- Assert `rst` mid-RUN with max=5: all outputs are 0 immediately, `busy_o`=0, and a following start runs normally.

Source files
------------

// File: rtl/dna_max_tracker.sv
// Result collector for the Smith-Waterman PE array: tracks the maximum cell
// score and its (row, col) over a row-major stream, then hands it to the host.
module dna_max_tracker #(
    parameter int unsigned SCORE_W = 32,
    parameter int unsigned ROW_W   = 8,
    parameter int unsigned COL_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ROW_W-1:0]   num_rows_i,
    input  logic [COL_W-1:0]   num_cols_i,
    input  logic               en_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic               res_ready_i,
    output logic               busy_o,
    output logic               res_valid_o,
    output logic [SCORE_W-1:0] max_score_o,
    output logic [ROW_W-1:0]   max_row_o,
    output logic [COL_W-1:0]   max_col_o,
    output logic               drop_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   rows_q, rows_d, row_cnt_q, row_cnt_d;
    logic [COL_W-1:0]   cols_q, cols_d, col_cnt_q, col_cnt_d;
    logic [SCORE_W-1:0] max_score_q, max_score_d;
    logic [ROW_W-1:0]   max_row_q, max_row_d;
    logic [COL_W-1:0]   max_col_q, max_col_d;
    logic               drop_q, drop_d;
    logic               restart;
    logic               last_col;

    // In DONE a start only takes effect together with the result being consumed.
    assign restart  = start_i && ((state_q != DONE) || res_ready_i);
    assign last_col = (col_cnt_q == cols_q - COL_W'(1));

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        max_score_d = max_score_q;
        max_row_d   = max_row_q;
        max_col_d   = max_col_q;
        drop_d      = drop_q;

        if (en_i && (state_q != RUN)) drop_d = 1'b1;

        if (restart) begin
            rows_d      = num_rows_i;
            cols_d      = num_cols_i;
            row_cnt_d   = '0;
            col_cnt_d   = '0;
            max_score_d = '0;
            max_row_d   = '0;
            max_col_d   = '0;
            drop_d      = 1'b0;
            state_d     = ((num_rows_i == '0) || (num_cols_i == '0)) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (en_i) begin
                        if (score_i > max_score_q) begin
                            max_score_d = score_i;
                            max_row_d   = row_cnt_q;
                            max_col_d   = col_cnt_q;
                        end
                        if (last_col) begin
                            col_cnt_d = '0;
                            if (row_cnt_q == rows_q - ROW_W'(1)) begin
                                state_d = DONE;
                            end else begin
                                row_cnt_d = row_cnt_q + ROW_W'(1);
                            end
                        end else begin
                            col_cnt_d = col_cnt_q + COL_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            max_score_q <= '0;
            max_row_q   <= '0;
            max_col_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            max_score_q <= max_score_d;
            max_row_q   <= max_row_d;
            max_col_q   <= max_col_d;
            drop_q      <= drop_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign res_valid_o = (state_q == DONE);
    assign max_score_o = max_score_q;
    assign max_row_o   = max_row_q;
    assign max_col_o   = max_col_q;
    assign drop_o      = drop_q;

endmodule
